// File: rtl/rr_grant_8.sv
// rr_grant_8: eight-way round-robin arbiter driving a one-hot D[7:0]
// with a registered grant, hold limit and a one-cycle gap between grants.
module rr_grant_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] D,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] grant_q, grant_d;
    logic       gv_q, gv_d;
    logic       to_q, to_d;

    logic [2:0] pick;
    logic       found;
    logic       hit_max;
    logic       rel;

    // Rotating scan: first requester at or after ptr wins
    always_comb begin
        logic [2:0] j;
        pick  = ptr_q;
        found = 1'b0;
        j     = ptr_q;
        for (int i = 0; i < 8; i++) begin
            j = ptr_q + 3'(i);
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
    end

    assign hit_max = (hold_q == HOLD_LAST);
    assign rel     = done || !req[idx_q] || hit_max;

    // Next-state logic for grant issue, hold and release
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    grant_d = 8'd1 << pick;
                    gv_d    = 1'b1;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    grant_d = 8'd0;
                    gv_d    = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    state_d = IDLE;
                    to_d    = hit_max && !done && req[idx_q];
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'd0;
                gv_d    = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            hold_q  <= 8'd0;
            grant_q <= 8'd0;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            to_q    <= to_d;
        end
    end

    assign D           = grant_q;
    assign grant_valid = gv_q;
    assign timeout     = to_q;

endmodule
